// File: rtl/fifoptrsync_if.sv
// Pointer-exchange bundle for one side of the async FIFO status logic.
// master drives the pointers; slave (fifoptrsync) returns sync/decode/status.
interface fifoptrsync_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] oppgray;
  logic [WIDTH-1:0] localbinary;
  logic [WIDTH-1:0] syncgray;
  logic [WIDTH-1:0] oppbinary;
  logic [WIDTH-1:0] level;
  logic             almost;
  logic             err;

  modport master (
    output oppgray, localbinary,
    input  syncgray, oppbinary, level, almost, err
  );

  modport slave (
    input  oppgray, localbinary,
    output syncgray, oppbinary, level, almost, err
  );
endinterface

// File: rtl/fifoptrsync.sv
// Receive side of the async FIFO gray-pointer exchange: sync, decode, level, almost flag.
// Optional sticky occupancy-violation flag enabled by defining FIFOPTRSYNC_ERR_EN.
module fifoptrsync #(
  parameter int WIDTH      = 9,
  parameter int MODE       = 0,
  parameter int SYNCSTAGES = 2,
  parameter int ALMOST     = 4
) (
  input logic         clock,
  input logic         reset,
  fifoptrsync_if.slave bus
);
  localparam int DEPTH = 1 << (WIDTH - 1);
  localparam logic [WIDTH-1:0] TH_FULL  = WIDTH'(DEPTH - ALMOST);
  localparam logic [WIDTH-1:0] TH_EMPTY = WIDTH'(ALMOST);

  logic [WIDTH-1:0] sync_q [SYNCSTAGES];
  logic [WIDTH-1:0] oppbinary_q;
  logic [WIDTH-1:0] level_q;
  logic             almost_q;
  logic [WIDTH-1:0] next_level;
  logic             almost_next;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain: each oppgray bit lands directly in stage 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNCSTAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.oppgray;
      for (int k = 1; k < SYNCSTAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Modulo-2^WIDTH subtract; the wrap bit makes full/empty distinguishable.
  always_comb begin
    next_level  = '0;
    almost_next = 1'b0;
    if (MODE == 0) begin
      next_level  = bus.localbinary - oppbinary_q;
      almost_next = (next_level >= TH_FULL);
    end else begin
      next_level  = oppbinary_q - bus.localbinary;
      almost_next = (next_level <= TH_EMPTY);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oppbinary_q <= '0;
      level_q     <= '0;
      almost_q    <= (MODE == 1);
    end else begin
      oppbinary_q <= gray2bin(sync_q[SYNCSTAGES-1]);
      level_q     <= next_level;
      almost_q    <= almost_next;
    end
  end

`ifdef FIFOPTRSYNC_ERR_EN
  logic err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (next_level > WIDTH'(DEPTH)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.syncgray  = sync_q[SYNCSTAGES-1];
  assign bus.oppbinary = oppbinary_q;
  assign bus.level     = level_q;
  assign bus.almost    = almost_q;
endmodule

// File: tb/tb_fifoptrsync.sv
// Scoreboard bench for fifoptrsync: one enqueue-side and one dequeue-side instance.
module tb_fifoptrsync;
  localparam int W  = 9;
  localparam int SG = 0, OB = 1, LV = 2, AL = 3, ER = 4;
`ifdef FIFOPTRSYNC_ERR_EN
  localparam int ERRV = 1;
`else
  localparam int ERRV = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fifoptrsync_if #(.WIDTH(W)) b0 ();
  fifoptrsync_if #(.WIDTH(W)) b1 ();

  fifoptrsync #(.WIDTH(W), .MODE(0), .SYNCSTAGES(2), .ALMOST(4)) dut0 (
    .clock(clk), .reset(rst), .bus(b0)
  );
  fifoptrsync #(.WIDTH(W), .MODE(1), .SYNCSTAGES(2), .ALMOST(4)) dut1 (
    .clock(clk), .reset(rst), .bus(b1)
  );

  typedef struct {
    int    cyc;
    int    dut;
    int    fld;
    int    val;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int peek(input int d, input int f);
    if (d == 0) begin
      case (f)
        SG:      return int'(b0.syncgray);
        OB:      return int'(b0.oppbinary);
        LV:      return int'(b0.level);
        AL:      return int'(b0.almost);
        default: return int'(b0.err);
      endcase
    end else begin
      case (f)
        SG:      return int'(b1.syncgray);
        OB:      return int'(b1.oppbinary);
        LV:      return int'(b1.level);
        AL:      return int'(b1.almost);
        default: return int'(b1.err);
      endcase
    end
  endfunction

  always @(negedge clk) begin
    int act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cycle) begin
        act = peek(q[i].dut, q[i].fld);
        n_cmp++;
        if (act != q[i].val) begin
          n_bad++;
          $display("FAIL %s (dut%0d): got 0x%0h expected 0x%0h at cycle %0d",
                   q[i].tag, q[i].dut, act, q[i].val, cycle);
        end
        q.delete(i);
      end
    end
  end

  function automatic logic [W-1:0] gray(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  task automatic push_exp(input int dly, input int d, input int f, input int v, input string t);
    exp_t e;
    e.cyc = cycle + dly;
    e.dut = d;
    e.fld = f;
    e.val = v;
    e.tag = t;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 20) begin
      tick(1);
      k++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d checks pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b0.oppgray = '0; b0.localbinary = '0;
    b1.oppgray = '0; b1.localbinary = '0;
    tick(2);
    push_exp(0, 0, LV, 0, "rst_level");
    push_exp(0, 0, AL, 0, "rst_almost_full");
    push_exp(0, 0, ER, 0, "rst_err");
    push_exp(0, 1, AL, 1, "rst_almost_empty");
    push_exp(0, 1, LV, 0, "rst_level");
    drain();
    rst = 1'b0;

    // latency: local 5, opp 2
    b0.localbinary = 9'h005;
    b0.oppgray = gray(2);
    push_exp(1, 0, SG, 0, "lat_sg_early");
    push_exp(2, 0, SG, 9'h003, "lat_syncgray");
    push_exp(3, 0, OB, 2, "lat_oppbinary");
    push_exp(4, 0, LV, 3, "lat_level");
    push_exp(4, 0, AL, 0, "lat_almost");
    drain();
    b0.localbinary = 9'h006;
    push_exp(1, 0, LV, 4, "local_step_level");
    drain();

    // asynchronous reset in the middle of a cycle
    @(posedge clk); #3;
    rst = 1'b1;
    push_exp(0, 0, LV, 0, "midrst_level");
    push_exp(0, 0, OB, 0, "midrst_oppbinary");
    push_exp(0, 0, SG, 0, "midrst_syncgray");
    push_exp(0, 0, AL, 0, "midrst_almost");
    push_exp(0, 0, ER, 0, "midrst_err");
    push_exp(0, 1, AL, 1, "midrst_almost_empty");
    drain();
    rst = 1'b0;
    push_exp(4, 0, LV, 4, "postrst_level");
    drain();

    // wrap-around and full extreme
    b0.localbinary = 9'h101;
    b0.oppgray = gray(9'h0FE);
    push_exp(4, 0, LV, 3, "wrap_level");
    push_exp(4, 0, AL, 0, "wrap_almost");
    drain();
    b0.localbinary = 9'h100;
    b0.oppgray = gray(0);
    push_exp(4, 0, LV, 256, "full_level");
    push_exp(4, 0, AL, 1, "full_almost");
    drain();
    b0.localbinary = 9'h0FB;
    push_exp(1, 0, LV, 251, "af_below_level");
    push_exp(1, 0, AL, 0, "af_below_almost");
    drain();
    b0.localbinary = 9'h0FC;
    push_exp(1, 0, LV, 252, "af_edge_level");
    push_exp(1, 0, AL, 1, "af_edge_almost");
    drain();

    // dequeue side almost-empty
    b1.localbinary = 9'h010;
    b1.oppgray = gray(9'h015);
    push_exp(4, 1, LV, 5, "ae_above_level");
    push_exp(4, 1, AL, 0, "ae_above_almost");
    drain();
    b1.oppgray = gray(9'h014);
    push_exp(4, 1, LV, 4, "ae_edge_level");
    push_exp(4, 1, AL, 1, "ae_edge_almost");
    drain();
    b1.oppgray = gray(9'h010);
    push_exp(4, 1, LV, 0, "empty_level");
    push_exp(4, 1, AL, 1, "empty_almost");
    drain();
    b1.oppgray = gray(9'h110);
    push_exp(4, 1, LV, 256, "deq_depth_level");
    push_exp(4, 1, AL, 0, "deq_depth_almost");
    drain();

    // gray decode sweep
    b0.localbinary = '0;
    for (int i = 0; i < 512; i++) begin
      b0.oppgray = gray(i);
      push_exp(3, 0, OB, i, "sweep_oppbinary");
      tick(4);
    end
    drain();

    // occupancy violation flag
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    b0.localbinary = 9'h120;
    b0.oppgray = gray(0);
    push_exp(4, 0, LV, 9'h120, "err_level");
    push_exp(4, 0, ER, ERRV, "err_set");
    drain();
    b0.oppgray = gray(9'h120);
    push_exp(4, 0, LV, 0, "err_back_level");
    push_exp(4, 0, ER, ERRV, "err_sticky");
    drain();
    rst = 1'b1;
    push_exp(0, 0, ER, 0, "err_cleared");
    drain();
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
